// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package ssd_pkg;

  // Glyph table indexed by nibble value; the rightmost entry is glyph 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Everything the display needs to know about one digit position.
  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       blank;
  } digit_t;

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bus between the value source (master) and the scan driver (slave).
// The blink_mask signal exists only when SSD_BLINK_EN is defined.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_en;
  logic                    pending;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
`ifdef SSD_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;

  modport master (
    output value, load, dp_mask, blank_mask, lz_en, blink_mask,
    input  pending, seg, dp, an
  );
  modport slave (
    input  value, load, dp_mask, blank_mask, lz_en, blink_mask,
    output pending, seg, dp, an
  );
`else
  modport master (
    output value, load, dp_mask, blank_mask, lz_en,
    input  pending, seg, dp, an
  );
  modport slave (
    input  value, load, dp_mask, blank_mask, lz_en,
    output pending, seg, dp, an
  );
`endif
endinterface

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a frame-synchronous
// double buffer, leading-zero suppression, blanking, decimal points and an
// anode dead time at the start of every digit slot.
// Optional blinking is compiled in with the SSD_BLINK_EN macro.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 2
`ifdef SSD_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input logic              clk,
  input logic              reset,
  ssd_scan_driver_if.slave bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_DEAD = DIV_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_end;
  digit_t                in_dig  [NUM_DIGITS];
  digit_t                buf_dig [NUM_DIGITS];
  digit_t                act_dig [NUM_DIGITS];
  logic                  pending;
  logic [NUM_DIGITS-1:0] sup;
  logic                  run;
  digit_t                cur;
  logic [6:0]            hex_seg;
  logic                  blink_off;
  logic                  dark;
  logic                  dp_on;
  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [NUM_DIGITS-1:0] an_p1;

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot divider and digit sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (slot_end) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Regroup the packed input buses into per-digit records.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_dig[i] = '{nibble: bus.value[4*i +: 4], dp: bus.dp_mask[i], blank: bus.blank_mask[i]};
    end
  end

  // Double buffer: loads land in the pending copy and are promoted only at a
  // frame boundary, so a frame never mixes old and new digits. A load on the
  // boundary cycle itself bypasses the pending copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_dig[i] <= '0;
        act_dig[i] <= '0;
      end
    end else if (bus.load && frame_end) begin
      act_dig <= in_dig;
      pending <= 1'b0;
    end else if (bus.load) begin
      buf_dig <= in_dig;
      pending <= 1'b1;
    end else if (frame_end && pending) begin
      act_dig <= buf_dig;
      pending <= 1'b0;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  logic [FC_W-1:0] fcnt;
  logic            phase_on;

  // Frame counter toggling the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (frame_end) begin
      if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blink_off = ~phase_on & bus.blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  // Leading-zero run from the top digit down; digit 0 is never suppressed.
  always_comb begin
    sup = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run    = run & (act_dig[i].nibble == 4'h0);
      sup[i] = run & bus.lz_en;
    end
  end

  assign cur = act_dig[idx];

  ssd_hex_decode u_dec (
    .nibble (cur.nibble),
    .seg    (hex_seg)
  );

  // Suppression keeps the decimal point; blanking and blink-off do not.
  assign dark  = cur.blank | sup[idx] | blink_off;
  assign dp_on = cur.dp & ~cur.blank & ~blink_off;

  // ---- stage p1: registered pin drive, one cycle behind div/idx ----
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b1;
      an_p1  <= '1;
    end else begin
      seg_p1 <= dark ? SEG_OFF : hex_seg;
      dp_p1  <= ~dp_on;
      an_p1  <= (div < DIV_DEAD) ? '1 : ~(NUM_DIGITS'(1) << idx);
    end
  end

  assign bus.pending = pending;
  assign bus.seg     = seg_p1;
  assign bus.dp      = dp_p1;
  assign bus.an      = an_p1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: 4 digits, 8 clocks per slot, 2 dead
// cycles, so one frame is 32 clocks. k counts edges since reset release;
// outputs seen after edge k reflect scan position t = k-1.
module tb_ssd_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   k = 0;

  always #5 clk = ~clk;

  ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .DEAD_CYCLES  (DC)
`ifdef SSD_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int tk);
    while (k < tk) cycle();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blm);
    bus.value      = v;
    bus.dp_mask    = dpm;
    bus.blank_mask = blm;
    bus.load       = 1'b1;
    cycle();
    bus.load       = 1'b0;
  endtask

  // Check each digit of frame f in the middle of its slot (div = 4).
  task automatic check_frame(input int f, input logic [3:0][6:0] es, input logic [3:0] edp,
                             input string tag);
    logic [3:0] ea;
    for (int i = 0; i < ND; i++) begin
      goto(32*f + 8*i + 5);
      ea    = 4'b1111;
      ea[i] = 1'b0;
      chk({tag, "_seg"}, 32'(bus.seg), 32'(es[i]));
      chk({tag, "_dp"},  32'(bus.dp),  32'(edp[i]));
      chk({tag, "_an"},  32'(bus.an),  32'(ea));
    end
  endtask

  initial begin
    int t;
    int dv;
    int ix;
    logic [3:0] ea;

    bus.value      = '0;
    bus.load       = 1'b0;
    bus.dp_mask    = '0;
    bus.blank_mask = '0;
    bus.lz_en      = 1'b0;
`ifdef SSD_BLINK_EN
    bus.blink_mask = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(bus.seg), 32'h7f);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_an", 32'(bus.an), 32'hf);
    chk("rst_pending", 32'(bus.pending), 32'h0);

    reset = 1'b0;
    k = 0;

    // Frame 0: anode timing every cycle, with a load of 1A3F mid-frame.
    for (int j = 1; j <= 32; j++) begin
      if (k == 10) begin
        bus.value   = 16'h1A3F;
        bus.dp_mask = 4'b0100;
        bus.load    = 1'b1;
      end
      cycle();
      if (k == 11) bus.load = 1'b0;
      t  = k - 1;
      dv = t % SD;
      ix = t / SD;
      ea = 4'b1111;
      if (dv >= DC) ea[ix] = 1'b0;
      chk("an_vs_div", 32'(bus.an), 32'(ea));
      if (k == 3) begin
        chk("first_digit_seg", 32'(bus.seg), 32'h40);
        chk("first_digit_dp", 32'(bus.dp), 32'h1);
      end
      if (k == 11 || k == 31) chk("pending_set", 32'(bus.pending), 32'h1);
      if (k == 32) chk("pending_clr", 32'(bus.pending), 32'h0);
    end

    check_frame(1, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1011, "f1_1A3F");

    goto(61);
    bus.lz_en = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    chk("pending_0050", 32'(bus.pending), 32'h1);
    check_frame(2, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111, "f2_lz0050");

    goto(93);
    do_load(16'h0000, 4'b1000, 4'b0000);
    goto(97);
    do_load(16'h1111, 4'b0000, 4'b0000);
    chk("pending_1111", 32'(bus.pending), 32'h1);
    check_frame(3, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0111, "f3_lzzero");

    bus.lz_en = 1'b0;
    do_load(16'h2222, 4'b0000, 4'b0000);
    goto(127);
    chk("pending_2222", 32'(bus.pending), 32'h1);
    goto(128);
    chk("pending_bnd", 32'(bus.pending), 32'h0);
    check_frame(4, {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111, "f4_overwrite");

    // Load sampled on the exact boundary edge.
    goto(159);
    do_load(16'h3333, 4'b0011, 4'b0001);
    chk("pending_exact_bnd", 32'(bus.pending), 32'h0);
    check_frame(5, {7'b0110000, 7'b0110000, 7'b0110000, 7'b1111111}, 4'b1101, "f5_blank");

    // Reset mid-frame with data pending.
    goto(204);
    do_load(16'h4444, 4'b0000, 4'b0000);
    chk("pending_pre_rst", 32'(bus.pending), 32'h1);
    reset = 1'b1;
    cycle();
    chk("midrst_seg", 32'(bus.seg), 32'h7f);
    chk("midrst_dp", 32'(bus.dp), 32'h1);
    chk("midrst_an", 32'(bus.an), 32'hf);
    chk("midrst_pending", 32'(bus.pending), 32'h0);
    reset = 1'b0;
    k = 0;
    check_frame(0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111, "post_rst_f0");
    check_frame(1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111, "post_rst_f1");

`ifdef SSD_BLINK_EN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    k = 0;
    bus.blink_mask = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      check_frame(f, {7'b1000000, 7'b1000000, 7'b1000000,
                      ((f == 2 || f == 3) ? 7'b1111111 : 7'b1000000)}, 4'b1111, "blink");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
